// File: rtl/fetch_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_stage_if : instruction ROM port between fetch stage and ROM        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface fetch_stage_if #(
  parameter int unsigned A_WIDTH = 12
);
  logic [A_WIDTH-1:0] imem_addr_o;
  logic [31:0]        imem_rd_i;

  modport master (output imem_addr_o, input imem_rd_i);
  modport slave  (input imem_addr_o, output imem_rd_i);
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_stage : PC, next-PC select and IF/ID register feeding decode.      |
// | Optional macro FETCH_FAULT_EN adds misalign/out-of-range fault trapping. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'hBFC00000,
  parameter int unsigned A_WIDTH   = 12,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        stall_i,
  input  wire logic        flush_i,
  input  wire logic [1:0]  pc_src_i,
  input  wire logic [31:0] branch_target_i,
  input  wire logic [31:0] jalr_target_i,
  fetch_stage_if.master    imem,
  output logic [31:0]      pc_o,
  output logic             if_id_valid_o,
  output logic [31:0]      if_id_instr_o,
  output logic [31:0]      if_id_pc_o,
  output logic [31:0]      if_id_pc4_o,
  output logic             fetch_fault_o
);

  localparam logic [1:0] c_SRC_BRANCH = 2'b01;
  localparam logic [1:0] c_SRC_JALR   = 2'b10;

`ifdef FETCH_FAULT_EN
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1
  } state_t;
`endif

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc4;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_jalr_pc;
  logic [31:0] w_next_pc;
  logic        w_redirect;
  logic        w_pc_en;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_jalr_pc  = jalr_target_i & ~32'h1;
  assign w_redirect = (pc_src_i == c_SRC_BRANCH) || (pc_src_i == c_SRC_JALR);
  // A redirect from EX must land even while the hazard unit holds fetch.
  assign w_pc_en    = !stall_i || w_redirect;

  always_comb begin
    w_next_pc = w_pc_plus4;
    case (pc_src_i)
      c_SRC_BRANCH: w_next_pc = branch_target_i;
      c_SRC_JALR:   w_next_pc = w_jalr_pc;
      default:      w_next_pc = w_pc_plus4;
    endcase
  end

`ifdef FETCH_FAULT_EN
  logic [31:0] w_off;
  logic        w_fault;
  logic        r_fault;

  // Offset below the base wraps to a huge value, so one upper-bits test covers both ends.
  assign w_off   = r_pc - RESET_PC;
  assign w_fault = (r_pc[1:0] != 2'b00) || ((w_off >> A_WIDTH) != 32'd0);
  assign fetch_fault_o = r_fault;
`else
  assign fetch_fault_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_BOOT;
      r_pc     <= RESET_PC;
      r_valid  <= 1'b0;
      r_instr  <= NOP_INSTR;
      r_if_pc  <= 32'd0;
      r_if_pc4 <= 32'd0;
`ifdef FETCH_FAULT_EN
      r_fault  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_RUN;
          r_valid <= 1'b0;
          r_instr <= NOP_INSTR;
        end
        ST_RUN: begin
`ifdef FETCH_FAULT_EN
          if (w_fault) begin
            r_state <= ST_FAULT;
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_fault <= 1'b1;
          end else
`endif
          begin
            if (w_pc_en) begin
              r_pc <= w_next_pc;
            end
            if (flush_i) begin
              r_valid <= 1'b0;
              r_instr <= NOP_INSTR;
            end else if (!stall_i) begin
              r_valid  <= 1'b1;
              r_instr  <= imem.imem_rd_i;
              r_if_pc  <= r_pc;
              r_if_pc4 <= w_pc_plus4;
            end
          end
        end
`ifdef FETCH_FAULT_EN
        ST_FAULT: begin
          r_valid <= 1'b0;
          r_instr <= NOP_INSTR;
          r_fault <= 1'b1;
        end
`endif
        default: begin
          r_state <= ST_BOOT;
          r_valid <= 1'b0;
          r_instr <= NOP_INSTR;
        end
      endcase
    end
  end

  // Upper PC bits live only in r_pc; the ROM sees the low offset.
  assign imem.imem_addr_o = r_pc[A_WIDTH-1:0];
  assign pc_o             = r_pc;
  assign if_id_valid_o    = r_valid;
  assign if_id_instr_o    = r_instr;
  assign if_id_pc_o       = r_if_pc;
  assign if_id_pc4_o      = r_if_pc4;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// Directed bench for fetch_stage; ROM word at offset A is 32'hC0DE0000 | A.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [1:0]  pc_src;
  logic [31:0] br_tgt;
  logic [31:0] jalr_tgt;
  logic [31:0] pc;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        fault;

  int total;
  int bad;

  fetch_stage_if #(.A_WIDTH(12)) bus ();

  assign bus.imem_rd_i = 32'hC0DE0000 | {20'd0, bus.imem_addr_o};

  fetch_stage #(
    .RESET_PC (32'hBFC00000),
    .A_WIDTH  (12),
    .NOP_INSTR(32'h00000013)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall),
    .flush_i        (flush),
    .pc_src_i       (pc_src),
    .branch_target_i(br_tgt),
    .jalr_target_i  (jalr_tgt),
    .imem           (bus),
    .pc_o           (pc),
    .if_id_valid_o  (valid),
    .if_id_instr_o  (instr),
    .if_id_pc_o     (if_pc),
    .if_id_pc4_o    (if_pc4),
    .fetch_fault_o  (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; pc_src = 2'b00;
    br_tgt = 32'd0; jalr_tgt = 32'd0;
    #12;
    total++; if (pc !== 32'hBFC00000) begin bad++; $display("FAIL rst_pc got=%h exp=bfc00000", pc); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid); end
    total++; if (instr !== 32'h00000013) begin bad++; $display("FAIL rst_instr got=%h exp=00000013", instr); end
    total++; if (if_pc !== 32'd0 || if_pc4 !== 32'd0) begin bad++; $display("FAIL rst_ifpc got=%h/%h exp=0/0", if_pc, if_pc4); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%b exp=0", fault); end
    rst_n = 1'b1;
    step();
    total++; if (valid !== 1'b0 || pc !== 32'hBFC00000) begin bad++; $display("FAIL boot_c1 got=%b/%h exp=0/bfc00000", valid, pc); end
    step();
    total++; if (valid !== 1'b1 || if_pc !== 32'hBFC00000 || pc !== 32'hBFC00004) begin bad++; $display("FAIL boot_c2 got=%b/%h/%h exp=1/bfc00000/bfc00004", valid, if_pc, pc); end
  endtask

  task automatic test_seq();
    logic [31:0] exp_pc;
    exp_pc = 32'hBFC00000;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) step();
      total++; if (instr !== (32'hC0DE0000 | (exp_pc & 32'hFFF)) || if_pc !== exp_pc || if_pc4 !== exp_pc + 32'd4 || valid !== 1'b1) begin
        bad++; $display("FAIL seq_%0d got=%h@%h pc4=%h exp=%h@%h", i, instr, if_pc, if_pc4, 32'hC0DE0000 | (exp_pc & 32'hFFF), exp_pc);
      end
      exp_pc = exp_pc + 32'd4;
    end
    total++; if (pc !== 32'hBFC00010) begin bad++; $display("FAIL seq_pc got=%h exp=bfc00010", pc); end
  endtask

  task automatic test_stall();
    pc_src = 2'b01; br_tgt = 32'hBFC00008;
    step();
    pc_src = 2'b00;
    total++; if (pc !== 32'hBFC00008 || if_pc !== 32'hBFC00010 || instr !== 32'hC0DE0010) begin bad++; $display("FAIL stall_pre got=%h/%h/%h exp=bfc00008/bfc00010/c0de0010", pc, if_pc, instr); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (pc !== 32'hBFC00008 || if_pc !== 32'hBFC00010 || instr !== 32'hC0DE0010 || valid !== 1'b1) begin
        bad++; $display("FAIL stall_hold_%0d got=%h/%h/%h exp=bfc00008/bfc00010/c0de0010", i, pc, if_pc, instr);
      end
    end
    stall = 1'b0;
    step();
    total++; if (pc !== 32'hBFC0000C || if_pc !== 32'hBFC00008 || instr !== 32'hC0DE0008) begin bad++; $display("FAIL stall_resume got=%h/%h/%h exp=bfc0000c/bfc00008/c0de0008", pc, if_pc, instr); end
  endtask

  task automatic test_redirect_flush();
    pc_src = 2'b01; br_tgt = 32'hBFC00100; flush = 1'b1; stall = 1'b1;
    step();
    pc_src = 2'b00; flush = 1'b0; stall = 1'b0;
    total++; if (pc !== 32'hBFC00100) begin bad++; $display("FAIL rf_pc got=%h exp=bfc00100", pc); end
    total++; if (valid !== 1'b0 || instr !== 32'h00000013) begin bad++; $display("FAIL rf_bubble got=%b/%h exp=0/00000013", valid, instr); end
    step();
    total++; if (valid !== 1'b1 || if_pc !== 32'hBFC00100 || instr !== 32'hC0DE0100 || pc !== 32'hBFC00104) begin bad++; $display("FAIL rf_next got=%b/%h/%h/%h exp=1/bfc00100/c0de0100/bfc00104", valid, if_pc, instr, pc); end
  endtask

  task automatic test_jalr();
    pc_src = 2'b10; jalr_tgt = 32'hBFC00041;
    step();
    pc_src = 2'b00;
    total++; if (pc !== 32'hBFC00040) begin bad++; $display("FAIL jalr_pc got=%h exp=bfc00040", pc); end
    total++; if (bus.imem_addr_o !== 12'h040) begin bad++; $display("FAIL jalr_addr got=%h exp=040", bus.imem_addr_o); end
    step();
    total++; if (if_pc !== 32'hBFC00040 || instr !== 32'hC0DE0040) begin bad++; $display("FAIL jalr_cap got=%h/%h exp=bfc00040/c0de0040", if_pc, instr); end
  endtask

  task automatic test_wrap();
    pc_src = 2'b01; br_tgt = 32'hBFC00FFC;
    step();
    pc_src = 2'b00;
    total++; if (pc !== 32'hBFC00FFC || bus.imem_addr_o !== 12'hFFC) begin bad++; $display("FAIL wrap_top got=%h/%h exp=bfc00ffc/ffc", pc, bus.imem_addr_o); end
    step();
    total++; if (pc !== 32'hBFC01000 || bus.imem_addr_o !== 12'h000) begin bad++; $display("FAIL wrap_pc got=%h/%h exp=bfc01000/000", pc, bus.imem_addr_o); end
    total++; if (if_pc !== 32'hBFC00FFC || if_pc4 !== 32'hBFC01000 || instr !== 32'hC0DE0FFC) begin bad++; $display("FAIL wrap_cap got=%h/%h/%h exp=bfc00ffc/bfc01000/c0de0ffc", if_pc, if_pc4, instr); end
    step();
`ifdef FETCH_FAULT_EN
    total++; if (fault !== 1'b1 || valid !== 1'b0 || pc !== 32'hBFC01000) begin bad++; $display("FAIL fault_enter got=%b/%b/%h exp=1/0/bfc01000", fault, valid, pc); end
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (fault !== 1'b1 || valid !== 1'b0 || instr !== 32'h00000013 || pc !== 32'hBFC01000) begin
        bad++; $display("FAIL fault_hold_%0d got=%b/%b/%h/%h exp=1/0/00000013/bfc01000", i, fault, valid, instr, pc);
      end
    end
`else
    total++; if (valid !== 1'b1 || if_pc !== 32'hBFC01000 || instr !== 32'hC0DE0000 || pc !== 32'hBFC01004) begin bad++; $display("FAIL wrap_fetch got=%b/%h/%h/%h exp=1/bfc01000/c0de0000/bfc01004", valid, if_pc, instr, pc); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL wrap_nofault got=%b exp=0", fault); end
`endif
  endtask

  task automatic test_reset_mid();
    #2 rst_n = 1'b0;
    #1;
    total++; if (pc !== 32'hBFC00000 || valid !== 1'b0 || instr !== 32'h00000013) begin bad++; $display("FAIL mid_rst got=%h/%b/%h exp=bfc00000/0/00000013", pc, valid, instr); end
    total++; if (if_pc !== 32'd0 || if_pc4 !== 32'd0 || fault !== 1'b0) begin bad++; $display("FAIL mid_rst_ifid got=%h/%h/%b exp=0/0/0", if_pc, if_pc4, fault); end
    #2 rst_n = 1'b1;
    step();
    total++; if (valid !== 1'b0 || pc !== 32'hBFC00000) begin bad++; $display("FAIL mid_boot got=%b/%h exp=0/bfc00000", valid, pc); end
    step();
    total++; if (valid !== 1'b1 || if_pc !== 32'hBFC00000 || instr !== 32'hC0DE0000) begin bad++; $display("FAIL mid_run got=%b/%h/%h exp=1/bfc00000/c0de0000", valid, if_pc, instr); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_seq();
    test_stall();
    test_redirect_flush();
    test_jalr();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
